// File: rtl/gray_burst_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_burst_arbiter_pkg
// Description : Shared constants for the Gray burst arbiter: FSM state
//               encodings, Gray sequence end points and the next-Gray step.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_burst_arbiter_pkg;

   // Arbiter FSM state encodings
   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   // First and last codes of the 3-bit reflected Gray sequence
   localparam logic [2:0] c_GRAY_FIRST = 3'b000;
   localparam logic [2:0] c_GRAY_LAST  = 3'b100;

   // Next code in the sequence: decode to binary, increment, re-encode
   function automatic logic [2:0] gray_next(input logic [2:0] g);
      logic [2:0] b;
      b[2] = g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      b    = b + 3'd1;
      return b ^ {1'b0, b[2:1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/gray3_core.sv
`default_nettype none
// ============================================================================
// Module      : gray3_core
// Description : 3-bit Gray-code step counter with enable and synchronous
//               clear. Flags the 100->000 wrap as a same-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gray3_core
   import gray_burst_arbiter_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       en,
   input  logic       clr,
   output logic [2:0] gray,
   output logic       wrap
);

   logic [2:0] r_gray;

   // A wrap only counts when the step really happens (clear wins over it)
   assign wrap = en && !clr && (r_gray == c_GRAY_LAST);
   assign gray = r_gray;

   // Counter register: clear has priority over stepping
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_gray <= c_GRAY_FIRST;
      end else if (clr) begin
         r_gray <= c_GRAY_FIRST;
      end else if (en) begin
         r_gray <= gray_next(r_gray);
      end
   end

endmodule
`default_nettype wire

// File: rtl/gray_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_burst_arbiter
// Description : Round-robin arbiter granting fixed-length bursts of steps on a
//               shared 3-bit Gray counter, with sticky overflow and a
//               saturating wrap count. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_burst_arbiter
   import gray_burst_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int LEN_W  = 4,
   parameter int WRAP_W = 8
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [N_REQ-1:0]         Req,
   input  logic [N_REQ*LEN_W-1:0]   Len,
   input  logic                     Clr,
   output logic [N_REQ-1:0]         Gnt,
   output logic [N_REQ-1:0]         Done,
   output logic                     Abort,
   output logic                     Busy,
   output logic [2:0]               Gray,
   output logic                     Overflow,
   output logic [WRAP_W-1:0]        WrapCnt
);

   localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int c_SUM_W = c_PTR_W + 1;
   localparam logic [N_REQ-1:0] c_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [1:0]          r_state;
   logic [c_PTR_W-1:0]  r_ptr;
   logic [c_PTR_W-1:0]  r_win;
   logic [LEN_W-1:0]    r_rem;
   logic [N_REQ-1:0]    r_gnt;
   logic [N_REQ-1:0]    r_done;
   logic                r_abort;
   logic                r_overflow;
   logic [WRAP_W-1:0]   r_wrapcnt;

   logic [LEN_W-1:0]    w_len_arr [N_REQ];
   logic                w_found;
   logic [c_PTR_W-1:0]  w_winner;
   logic [c_SUM_W-1:0]  w_sum;
   logic [c_PTR_W-1:0]  w_idx;
   logic [LEN_W-1:0]    w_win_len;
   logic [N_REQ-1:0]    w_win_oh;
   logic                w_step;
   logic                w_wrap;

   // Unpack the flat length bus into one entry per requester
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_len_arr[i] = Len[i*LEN_W +: LEN_W];
      end
   end

   // Round-robin search starting at the pointer, wrapping modulo N_REQ
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + c_SUM_W'(i);
         if (w_sum >= c_SUM_W'(N_REQ)) begin
            w_sum = w_sum - c_SUM_W'(N_REQ);
         end
         w_idx = w_sum[c_PTR_W-1:0];
         if (!w_found && Req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_win_len = w_len_arr[w_winner];
   assign w_win_oh  = c_ONE << w_winner;
   assign w_step    = (r_state == c_ST_RUN) && !Clr;

   gray3_core u_core (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .en      (w_step),
      .clr     (Clr),
      .gray    (Gray),
      .wrap    (w_wrap)
   );

   // Burst FSM: grant, count down the burst, pulse Done, advance the pointer
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= c_ST_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_rem   <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_abort <= 1'b0;
      end else begin
         r_done  <= '0;
         r_abort <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (!Clr && w_found) begin
                  r_gnt <= w_win_oh;
                  r_win <= w_winner;
                  r_rem <= w_win_len;
                  if (w_win_len == '0) begin
                     r_state <= c_ST_DONE;
                     r_done  <= w_win_oh;
                  end else begin
                     r_state <= c_ST_RUN;
                  end
               end
            end
            c_ST_RUN: begin
               if (Clr) begin
                  r_state <= c_ST_DONE;
                  r_done  <= r_gnt;
                  r_abort <= 1'b1;
               end else begin
                  r_rem <= r_rem - LEN_W'(1);
                  if (r_rem == LEN_W'(1)) begin
                     r_state <= c_ST_DONE;
                     r_done  <= r_gnt;
                  end
               end
            end
            c_ST_DONE: begin
               r_gnt   <= '0;
               r_ptr   <= (r_win == c_PTR_W'(N_REQ - 1)) ? '0 : r_win + c_PTR_W'(1);
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_gnt   <= '0;
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   // Wrap statistics: clear overrides a simultaneous wrap
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_overflow <= 1'b0;
         r_wrapcnt  <= '0;
      end else if (Clr) begin
         r_overflow <= 1'b0;
         r_wrapcnt  <= '0;
      end else if (w_wrap) begin
         r_overflow <= 1'b1;
         if (r_wrapcnt != '1) begin
            r_wrapcnt <= r_wrapcnt + WRAP_W'(1);
         end
      end
   end

   assign Gnt      = r_gnt;
   assign Done     = r_done;
   assign Abort    = r_abort;
   assign Busy     = (r_state != c_ST_IDLE);
   assign Overflow = r_overflow;
   assign WrapCnt  = r_wrapcnt;

endmodule
`default_nettype wire
